dmem_store_buffer: RTL

//  Data-memory responder for the single-cycle core's load/store port (address = ALU result, writedata, readdata).

---
 rtl/mem_pkg.sv | 14 +
 rtl/store_fifo.sv | 51 +++++
 rtl/dmem_store_buffer.sv | 85 ++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared types and defaults for the data-memory store buffer.
// Entries pair a RAM word index with the data posted for it.
package mem_pkg;

  localparam int DATA_W     = 32;
  localparam int DEF_ADDR_W = 6;
  localparam int DEF_DEPTH  = 4;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] idx;
    logic [DATA_W-1:0]     data;
  } sb_entry_t;

endpackage

// File: rtl/store_fifo.sv
// Circular FIFO of posted stores. All entries and the head/count
// state are exported so the top level can search for forwarding hits.
module store_fifo
  import mem_pkg::*;
#(
  parameter  int  DEPTH   = DEF_DEPTH,
  parameter  type entry_t = sb_entry_t,
  localparam int  PTR_W   = $clog2(DEPTH),
  localparam int  CNT_W   = PTR_W + 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  entry_t                 push_entry,
  output entry_t [DEPTH-1:0]     entries,
  output logic   [PTR_W-1:0]     head,
  output logic   [CNT_W-1:0]     count,
  output logic                   full,
  output logic                   empty
);

  logic   [PTR_W-1:0] tail;
  entry_t [DEPTH-1:0] slots;

  // Push wins if both are ever raised together; the top never does that.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (push) begin
      tail  <= tail + PTR_W'(1);
      count <= count + CNT_W'(1);
    end else if (pop) begin
      head  <= head + PTR_W'(1);
      count <= count - CNT_W'(1);
    end
  end

  // NOTE: storage is deliberately not reset; count alone decides which
  // slots are valid, and a resettable array would cost a flop per bit.
  always_ff @(posedge clk) begin
    if (push) slots[tail] <= push_entry;
  end

  assign entries = slots;
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);

endmodule

// File: rtl/dmem_store_buffer.sv
// Data-memory responder: posts stores into a small FIFO, drains them to a
// single-ported word RAM on free cycles, and forwards buffered data to loads.
module dmem_store_buffer
  import mem_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic              re,
  input  logic [31:0]       a,
  input  logic [DATA_W-1:0] wd,
  output logic [DATA_W-1:0] rd,
  output logic              stall,
  output logic              empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int WORDS = 1 << ADDR_W;

  typedef struct packed {
    logic [ADDR_W-1:0] idx;
    logic [DATA_W-1:0] data;
  } entry_t;

  logic [ADDR_W-1:0]  idx;
  logic               full;
  logic               push;
  logic               drain;
  logic [PTR_W-1:0]   head;
  logic [CNT_W-1:0]   count;
  entry_t [DEPTH-1:0] entries;
  entry_t             head_entry;
  logic [DATA_W-1:0]  ram [WORDS];

  // Byte-offset and high address bits carry no meaning for a word RAM.
  logic unused_addr_bits;
  assign unused_addr_bits = &{1'b0, a[31:ADDR_W+2], a[1:0]};

  assign idx        = a[ADDR_W+1:2];
  assign stall      = we & full;
  assign push       = we & ~full;
  // The RAM port is free only when no load reads it and no store is taken;
  // draining during a stall is what lets the held store in next cycle.
  assign drain      = ~empty & ~re & ~push;
  assign head_entry = entries[head];

  store_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .pop        (drain),
    .push_entry ('{idx: idx, data: wd}),
    .entries    (entries),
    .head       (head),
    .count      (count),
    .full       (full),
    .empty      (empty)
  );

  always_ff @(posedge clk) begin
    if (drain) ram[head_entry.idx] <= head_entry.data;
  end

  // Walk oldest to youngest so the last hit, the youngest store, wins.
  always_comb begin
    entry_t e;
    rd = '0;
    e  = '0;
    if (re) begin
      rd = ram[idx];
      for (int i = 0; i < DEPTH; i++) begin
        e = entries[head + PTR_W'(i)];
        if ((CNT_W'(i) < count) && (e.idx == idx)) rd = e.data;
      end
    end
  end

endmodule
